cla_multicycle_adder: RTL

- Multi-cycle block carry-lookahead adder with valid/ready handshakes on both input and output.
- Operands are split into GROUP-bit groups. One group is resolved per clock.
- Inside a group: per-bit p = a^b and g = a&b, then lookahead carries c[i+1] = g[i] | (p[i] & c[i]). Group propagate/generate (P, G) produce the carry into the next group for the next cycle.
- Area-lean alternative to the fully combinational CLA; sits between operand registers and downstream consumers.

---
 rtl/cla_multicycle_adder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/cla_multicycle_adder.sv
// Multi-cycle block carry-lookahead adder.
// Resolves one GROUP-bit slice per clock with valid/ready on both sides.
module cla_multicycle_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NG = WIDTH / GROUP;
    localparam int IW = (NG > 1) ? $clog2(NG) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [IW-1:0]    r_idx;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             r_out_valid;
    logic             r_in_ready;

    logic [GROUP-1:0] w_ga;
    logic [GROUP-1:0] w_gb;
    logic [GROUP-1:0] w_p;
    logic [GROUP-1:0] w_g;
    logic [GROUP-1:0] w_c;
    logic [GROUP-1:0] w_s;
    logic             w_gp;
    logic             w_gg;
    logic             w_gco;
    logic             w_last;

    always_comb begin
        w_ga = '0;
        w_gb = '0;
        for (int k = 0; k < NG; k++) begin
            if (r_idx == IW'(k)) begin
                w_ga = r_a[k*GROUP +: GROUP];
                w_gb = r_b[k*GROUP +: GROUP];
            end
        end
        w_p = w_ga ^ w_gb;
        w_g = w_ga & w_gb;
        w_c = '0;
        w_c[0] = r_carry;
        for (int i = 0; i < GROUP - 1; i++) begin
            w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
        end
        w_s = w_p ^ w_c;
        // Group P/G are carry-independent; only the final OR sees the carry-in
        w_gp = &w_p;
        w_gg = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
            w_gg = w_g[i] | (w_p[i] & w_gg);
        end
        w_gco = w_gg | (w_gp & r_carry);
    end

    assign w_last = (r_idx == IW'(NG - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_carry    <= cin;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    for (int k = 0; k < NG; k++) begin
                        if (r_idx == IW'(k)) begin
                            r_sum[k*GROUP +: GROUP] <= w_s;
                        end
                    end
                    r_carry <= w_gco;
                    r_idx   <= r_idx + IW'(1);
                    if (w_last) begin
                        // w_c[GROUP-1] is c[WIDTH-1] on the top group
                        r_cout      <= w_gco;
                        r_ovf       <= w_gco ^ w_c[GROUP-1];
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule
